// File: rtl/prior_predict_serial_if.sv
// prior_predict_serial_if: request, data and status bundle for the serial Kalman prior predictor
interface prior_predict_serial_if #(parameter int N = 20);
  logic start, busy, done, sat;
  logic signed [N-1:0] x00_post, x10_post, f00, f01, f10, f11, h00, h01, h10, h11;
  logic signed [N-1:0] X00_prior, X10_prior, Z00_hat, Z10_hat;
  modport master (
    output start, x00_post, x10_post, f00, f01, f10, f11, h00, h01, h10, h11,
    input busy, done, sat, X00_prior, X10_prior, Z00_hat, Z10_hat
  );
  modport slave (
    input start, x00_post, x10_post, f00, f01, f10, f11, h00, h01, h10, h11,
    output busy, done, sat, X00_prior, X10_prior, Z00_hat, Z10_hat
  );
endinterface

// File: rtl/prior_predict_serial.sv
// prior_predict_serial: x_prior = F*x_post, z_hat = H*x_prior with one shared multiplier, one product per clock
module prior_predict_serial #(
  parameter int N = 20,
  parameter int FRAC = 10
) (
  input logic clk,
  input logic rst,
  prior_predict_serial_if.slave b
);
  localparam int W = 2 * N + 2;
  localparam logic signed [W-1:0] RND = W'(1) << (FRAC - 1);
  localparam logic signed [W-1:0] MAXV = {{(W - N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W - N + 1){1'b1}}, {(N - 1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Z, DONE} state_t;
  state_t state, nxt;
  logic [1:0] step;
  logic signed [N-1:0] x0, x1, f00, f01, f10, f11, h00, h01, h10, h11;
  logic signed [N-1:0] xp0, xp1, zh0, zh1, a, c, res;
  logic signed [2*N:0] acc;
  logic signed [2*N-1:0] prod;
  logic signed [W-1:0] sum, shr;
  logic hi, lo, sat, busy;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = b.start ? CALC_X : IDLE;
      CALC_X: nxt = &step ? CALC_Z : CALC_X;
      CALC_Z: nxt = &step ? DONE : CALC_Z;
      default: nxt = IDLE;
    endcase
  end
  // Z products use the already clamped N-bit X results
  assign a = state == CALC_Z ? (step[1] ? (step[0] ? h11 : h10) : (step[0] ? h01 : h00))
                             : (step[1] ? (step[0] ? f11 : f10) : (step[0] ? f01 : f00));
  assign c = state == CALC_Z ? (step[0] ? xp1 : xp0) : (step[0] ? x1 : x0);
  assign prod = $signed({{N{a[N-1]}}, a}) * $signed({{N{c[N-1]}}, c});
  assign sum = {acc[2*N], acc} + {{2{prod[2*N-1]}}, prod} + RND;
  assign shr = sum >>> FRAC;
  assign hi = shr > MAXV;
  assign lo = shr < MINV;
  assign res = hi ? MAXV[N-1:0] : lo ? MINV[N-1:0] : shr[N-1:0];
  assign busy = state == CALC_X || state == CALC_Z;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step <= '0;
      acc <= '0;
      sat <= 1'b0;
      xp0 <= '0;
      xp1 <= '0;
      zh0 <= '0;
      zh1 <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && b.start) begin
        {x0, x1} <= {b.x00_post, b.x10_post};
        {f00, f01, f10, f11} <= {b.f00, b.f01, b.f10, b.f11};
        {h00, h01, h10, h11} <= {b.h00, b.h01, b.h10, b.h11};
        acc <= '0;
        sat <= 1'b0;
        step <= '0;
      end
      if (busy) begin
        step <= step + 2'd1;
        acc <= step[0] ? '0 : {prod[2*N-1], prod};
        if (step[0]) begin
          sat <= sat | hi | lo;
          if (state == CALC_X) begin
            if (step[1]) xp1 <= res;
            else xp0 <= res;
          end else begin
            if (step[1]) zh1 <= res;
            else zh0 <= res;
          end
        end
      end
    end
  end
  assign b.busy = busy;
  assign b.done = state == DONE;
  assign b.sat = sat;
  assign b.X00_prior = xp0;
  assign b.X10_prior = xp1;
  assign b.Z00_hat = zh0;
  assign b.Z10_hat = zh1;
endmodule
